two_output_demux: RTL and testbench
===================================

// Module: two_output_demux
// PURPOSE
//  Routes one valid/ready stream to one of two output streams, chosen by select.
//  It is the splitting counterpart of the datapath 2:1 selectors.
//  Example use: steering memory read data to the IR path (select=0) or the MDR path (select=1).
//  Each output has a one-entry holding register, so each destination stalls independently.
// PARAMETERS
//  WIDTH   32   data width of in_data, out0_data, out1_data
// PORTS
//  clk          in   1      single clock; all state updates on rising edge
//  reset        in   1      synchronous, active-high reset
//  select       in   1      destination for the current input word: 0 -> out0, 1 -> out1
//  in_valid     in   1      in_data/select valid
//  in_ready     out  1      block accepts in_data this cycle
//  in_data      in   WIDTH  input word
//  out0_valid   out  1      out0_data holds a word
//  out0_ready   in   1      sink 0 takes the word
//  out0_data    out  WIDTH  word for sink 0
//  out1_valid   out  1      out1_data holds a word
//  out1_ready   in   1      sink 1 takes the word
//  out1_data    out  WIDTH  word for sink 1
// BEHAVIOUR
//  - Reset (sync, active-high) clears:
//    - out0_valid=0, out1_valid=0, out0_data=0, out1_data=0.
//    - in_ready=0 while reset is high.
//    - Counters are cleared as well (see CONFIGURATION).
//  - Per-output state, two states: EMPTY (valid=0) and FULL (valid=1).
//  - in_ready = !reset && (!outS_valid || outS_ready), where S = select.
//    - Combinational from select, the selected valid, and the selected ready.
//    - The non-selected output never affects in_ready.
//  - Accept: in_valid && in_ready at an edge.
//    - in_data is loaded into buffer S.
//    - outS_valid=1 from the next cycle. Latency is 1 cycle.
//  - Drain: outN_valid && outN_ready at an edge.
//    - Buffer N goes EMPTY, unless the same edge also accepts into N.
//    - Drain plus accept on the same N: stays FULL, new data loaded (full throughput).
//  - Accept into one output and drain of the other output may occur on the same edge.
//    Both take effect.
//  - Both outputs may drain on the same edge.
//  - While outN_valid=1 and outN_ready=0, outN_data is held bit-stable.
//  - outN_data keeps the last word after draining. Data is don't-care while valid=0.
//  - select is sampled only on the accept edge. Producer holds select and in_data stable while in_valid && !in_ready.
//  - No combinational path from in_data to outN_data. Outputs come from registers only.
//  - Reset mid-transfer discards any buffered words. No transfer completes on a reset edge.
// CONFIGURATION
//  DEMUX_COUNT_EN defined:
//    - Adds ports out0_count (out, 16) and out1_count (out, 16).
//    - Each counter increments by 1 on every drain of its output and wraps 0xFFFF -> 0x0000.
//    - Counters reset to 0.
//  DEMUX_COUNT_EN undefined:
//    - Neither port exists, no counter logic is built.
//    - All other behaviour is identical.
// TESTING
//  1 Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0, both valid=0, both data=0;
//    first cycle after release -> in_ready=1.
//  2 Route: sel=0, in=0xDEADBEEF, out0_ready=1 -> out0_valid=1 next cycle with 0xDEADBEEF, out1_valid stays 0;
//    repeat with sel=1, in=0x12345678 -> appears on out1 only.
//  3 Backpressure: out0_ready=0, send 0xA to out0 -> in_ready=0 for sel=0, still 1 for sel=1;
//    send 0xB to out1 -> accepted; out0_data holds 0xA until out0_ready=1.
//  4 Throughput: out0_ready=1, sel=0, 8 words back-to-back 1..8 -> in_ready stays 1,
//    out0 shows 1..8 on consecutive cycles.
//  5 Simultaneous: out0 FULL(0x11), out1 FULL(0x22), sel=0, in=0x33, both readies=1 on the same edge ->
//    out0_data=0x33 valid, out1_valid=0.
//  6 DEMUX_COUNT_EN: 65537 drains on out1 -> out1_count=1; out0_count=0; reset -> both counts 0.

Source files
------------

// File: rtl/two_output_demux.sv
// One valid/ready input steered by select into one of two single-entry output buffers.
// Optional DEMUX_COUNT_EN adds a 16-bit wrapping drain counter per output.
module two_output_demux #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_COUNT_EN
  ,
  output logic [15:0]      out0_count,
  output logic [15:0]      out1_count
`endif
);

  typedef enum logic {StEmpty, StFull} buf_state_e;

  buf_state_e       state0_q, state1_q;
  logic [WIDTH-1:0] data0_q, data1_q;
  logic             sel_valid, sel_ready;
  logic             accept, accept0, accept1;
  logic             drain0, drain1;

  assign out0_valid = (state0_q == StFull);
  assign out1_valid = (state1_q == StFull);
  assign out0_data  = data0_q;
  assign out1_data  = data1_q;

  // Only the addressed buffer gates the input; the other side never stalls it.
  assign sel_valid = select ? out1_valid : out0_valid;
  assign sel_ready = select ? out1_ready : out0_ready;
  assign in_ready  = !reset && (!sel_valid || sel_ready);

  assign accept  = in_valid && in_ready;
  assign accept0 = accept && !select;
  assign accept1 = accept && select;
  assign drain0  = out0_valid && out0_ready;
  assign drain1  = out1_valid && out1_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state0_q <= StEmpty;
      state1_q <= StEmpty;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      // A load on the draining edge keeps the buffer full for back-to-back flow.
      if (accept0) begin
        state0_q <= StFull;
        data0_q  <= in_data;
      end else if (drain0) begin
        state0_q <= StEmpty;
      end
      if (accept1) begin
        state1_q <= StFull;
        data1_q  <= in_data;
      end else if (drain1) begin
        state1_q <= StEmpty;
      end
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [15:0] count0_q, count1_q;

  assign out0_count = count0_q;
  assign out1_count = count1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count0_q <= '0;
      count1_q <= '0;
    end else begin
      if (drain0) count0_q <= count0_q + 16'd1;
      if (drain1) count1_q <= count1_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_two_output_demux.sv
// Scoreboard bench for two_output_demux: per-output expected-word queues filled on accept,
// drained and compared by an independent monitor; directed cases then randomized traffic.
module tb_two_output_demux;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid, out1_ready;
  logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_COUNT_EN
  logic [15:0]      out0_count, out1_count;
`endif

  two_output_demux #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .select    (select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data)
`ifdef DEMUX_COUNT_EN
    ,
    .out0_count(out0_count),
    .out1_count(out1_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [15:0]      cnt0_m, cnt1_m;
  bit               mon_en = 1'b0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples at negedge, i.e. the values the next rising edge will see.
  logic             hold0_p = 1'b0, hold1_p = 1'b0;
  logic [WIDTH-1:0] data0_p, data1_p;
  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    logic             exp_rdy;
    if (!reset && mon_en) begin
      chk("out0_valid", WIDTH'(out0_valid), WIDTH'(q0.size() != 0));
      chk("out1_valid", WIDTH'(out1_valid), WIDTH'(q1.size() != 0));
      exp_rdy = select ? (q1.size() == 0 || out1_ready) : (q0.size() == 0 || out0_ready);
      chk("in_ready", WIDTH'(in_ready), WIDTH'(exp_rdy));
      if (hold0_p && out0_valid) chk("out0_hold", out0_data, data0_p);
      if (hold1_p && out1_valid) chk("out1_hold", out1_data, data1_p);
      hold0_p = out0_valid && !out0_ready;
      hold1_p = out1_valid && !out1_ready;
      data0_p = out0_data;
      data1_p = out1_data;
`ifdef DEMUX_COUNT_EN
      chk("out0_count", WIDTH'(out0_count), WIDTH'(cnt0_m));
      chk("out1_count", WIDTH'(out1_count), WIDTH'(cnt1_m));
`endif
      if (out0_valid && out0_ready && q0.size() != 0) begin
        e = q0.pop_front();
        chk("out0_data", out0_data, e);
        cnt0_m++;
      end
      if (out1_valid && out1_ready && q1.size() != 0) begin
        e = q1.pop_front();
        chk("out1_data", out1_data, e);
        cnt1_m++;
      end
    end else begin
      hold0_p = 1'b0;
      hold1_p = 1'b0;
    end
  end

  // One cycle of stimulus; entered and left at posedge+1.
  task automatic step(input logic iv, input logic sel, input logic [WIDTH-1:0] d,
                      input logic r0, input logic r1, output logic acc);
    in_valid   = iv;
    select     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    if (acc) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    q0.delete();
    q1.delete();
    cnt0_m = '0;
    cnt1_m = '0;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic             acc;
    logic             pend;
    logic             sel_r;
    logic [WIDTH-1:0] d_r;

    reset      = 1'b1;
    in_valid   = 1'b1;
    select     = 1'b0;
    in_data    = 32'hFFFF_FFFF;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    cnt0_m     = '0;
    cnt1_m     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", WIDTH'(in_ready), '0);
    chk("rst_out0_valid", WIDTH'(out0_valid), '0);
    chk("rst_out1_valid", WIDTH'(out1_valid), '0);
    chk("rst_out0_data", out0_data, '0);
    chk("rst_out1_data", out1_data, '0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", WIDTH'(in_ready), 32'd1);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Routing to each side
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, acc);
    step(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, acc);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

    // Backpressure on out0 does not block out1
    step(1'b1, 1'b0, 32'hA, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 32'hB, 1'b0, 1'b0, acc);
    chk("bp_accept_out1", WIDTH'(acc), 32'd1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

    // Full throughput
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, WIDTH'(i), 1'b1, 1'b0, acc);
      chk("thru_accept", WIDTH'(acc), 32'd1);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, acc);

    // Simultaneous accept into out0 with drains of both
    step(1'b1, 1'b0, 32'h11, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 32'h22, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 32'h33, 1'b1, 1'b1, acc);
    chk("simul_out0_data", out0_data, 32'h33);
    chk("simul_out1_valid", WIDTH'(out1_valid), '0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

    // Randomized traffic with a mid-run reset; producer holds a stalled word
    pend  = 1'b0;
    sel_r = 1'b0;
    d_r   = '0;
    for (int n = 0; n < 3000; n++) begin
      logic iv;
      if (n == 1500) do_reset();
      if (pend) begin
        iv = 1'b1;
      end else begin
        iv    = ($urandom_range(0, 3) != 0);
        sel_r = 1'($urandom_range(0, 1));
        d_r   = $urandom;
      end
      step(iv, sel_r, d_r, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), acc);
      pend = iv && !acc;
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);

`ifdef DEMUX_COUNT_EN
    do_reset();
    @(posedge clk);
    #1;
    chk("cnt_rst0", WIDTH'(out0_count), '0);
    chk("cnt_rst1", WIDTH'(out1_count), '0);
    for (int i = 0; i < 65537; i++) step(1'b1, 1'b1, WIDTH'(i), 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
    chk("cnt_wrap1", WIDTH'(out1_count), 32'd1);
    chk("cnt_wrap0", WIDTH'(out0_count), '0);
    do_reset();
    #1;
    chk("cnt_clr0", WIDTH'(out0_count), '0);
    chk("cnt_clr1", WIDTH'(out1_count), '0);
`endif

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
